// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Direct-mapped cache controller. Sequences an external 16-entry tag/data
//   SRAM (one-hot wordline, posedge write, combinational read) and a backing
//   memory. Handles one request at a time:
//     read hit  -> respond from SRAM
//     read miss -> fetch from backing memory, fill the line, respond
//     write     -> write through to backing memory; on a hit the line is also
//                  updated, on a miss nothing is allocated.
//   Keeps per-line valid bits and saturating hit/miss counters.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   flush                         invalidate all lines (honoured in IDLE)
//   req_valid/req_ready           request handshake
//   req_we/req_addr/req_wdata     request command, {tag,index}, write data
//   resp_valid/resp_rdata/resp_hit one-cycle response strobe and payload
//   mem_req_valid/mem_req_ready   backing-memory request handshake
//   mem_we/mem_addr/mem_wdata     backing-memory command
//   mem_rvalid/mem_rdata          backing-memory read return
//   sram_we/sram_wl               SRAM write enable, one-hot wordline
//   sram_tag_in/sram_data_in      SRAM write payload
//   sram_tag_out/sram_data_out    SRAM read payload
//   hit_count/miss_count          lookup statistics
// -----------------------------------------------------------------------------
module cache_ctrl #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [TAG_W+INDEX_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_hit,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_we,
    output logic [TAG_W+INDEX_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       sram_we,
    output logic [(2**INDEX_W)-1:0]    sram_wl,
    output logic [TAG_W-1:0]           sram_tag_in,
    output logic [DATA_W-1:0]          sram_data_in,
    input  logic [TAG_W-1:0]           sram_tag_out,
    input  logic [DATA_W-1:0]          sram_data_out,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    localparam int LINES  = 2 ** INDEX_W;
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam logic [LINES-1:0] WL_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WAIT,
        S_MEM_WR,
        S_FILL,
        S_RESP
    } state_t;

    state_t              state, state_nxt;
    logic [LINES-1:0]    valid;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    // Single data register: holds the fill data (memory return or write data)
    // and doubles as the response payload.
    logic [DATA_W-1:0]   data_r;
    logic                hit_r;

    logic [INDEX_W-1:0]  lat_index;
    logic [TAG_W-1:0]    lat_tag;
    logic [LINES-1:0]    wl_dec;
    logic                lookup_hit;

    assign lat_index  = lat_addr[INDEX_W-1:0];
    assign lat_tag    = lat_addr[ADDR_W-1:INDEX_W];
    assign wl_dec     = WL_ONE << lat_index;
    assign lookup_hit = valid[lat_index] && (sram_tag_out == lat_tag);

    assign resp_rdata = data_r;
    assign resp_hit   = hit_r;

    // Next-state and output decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        sram_we       = 1'b0;
        sram_wl       = '0;
        sram_tag_in   = '0;
        sram_data_in  = '0;

        case (state)
            S_IDLE: begin
                req_ready = !flush;
                if (!flush && req_valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                sram_wl = wl_dec;
                if (lat_we)          state_nxt = S_MEM_WR;
                else if (lookup_hit) state_nxt = S_RESP;
                else                 state_nxt = S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_valid = 1'b1;
                mem_addr      = lat_addr;
                if (mem_req_ready) state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid) state_nxt = S_FILL;
            end
            S_MEM_WR: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = lat_addr;
                mem_wdata     = lat_wdata;
                // Write-no-allocate: only a hitting line is refreshed.
                if (mem_req_ready) state_nxt = hit_r ? S_FILL : S_RESP;
            end
            S_FILL: begin
                sram_we      = 1'b1;
                sram_wl      = wl_dec;
                sram_tag_in  = lat_tag;
                sram_data_in = data_r;
                state_nxt    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the valid bits are plain flops and are cleared by reset; the tag and
    // data arrays live in the external SRAM and are never reset -- a cleared
    // valid bit is what makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            valid      <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            data_r     <= '0;
            hit_r      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values regardless of statement order.
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    hit_r  <= lookup_hit;
                    // On a read miss this value is overwritten in MEM_WAIT.
                    data_r <= lat_we ? lat_wdata : sram_data_out;
                    if (lookup_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rvalid) data_r <= mem_rdata;
                end
                S_FILL: begin
                    valid[lat_index] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
//   Directed bench for cache_ctrl. Provides a behavioural 16-entry tag/data
//   SRAM and a backing memory that returns read data one cycle after its
//   request is accepted. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        sram_we;
    logic [15:0] sram_wl;
    logic [3:0]  sram_tag_in;
    logic [7:0]  sram_data_in;
    logic [3:0]  sram_tag_out;
    logic [7:0]  sram_data_out;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_ctrl #(
        .INDEX_W(4), .TAG_W(4), .DATA_W(8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sram_we(sram_we), .sram_wl(sram_wl),
        .sram_tag_in(sram_tag_in), .sram_data_in(sram_data_in),
        .sram_tag_out(sram_tag_out), .sram_data_out(sram_data_out),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // ---------------- SRAM model: posedge write, combinational read, bypass
    logic [3:0] s_tag  [LINES];
    logic [7:0] s_data [LINES];
    logic [3:0] s_idx;

    always_comb begin
        s_idx = '0;
        for (int i = 0; i < LINES; i++)
            if (sram_wl[i]) s_idx = 4'(i);
    end

    assign sram_tag_out  = (sram_wl == '0) ? '0 : (sram_we ? sram_tag_in  : s_tag[s_idx]);
    assign sram_data_out = (sram_wl == '0) ? '0 : (sram_we ? sram_data_in : s_data[s_idx]);

    // Stale contents use tag 3 everywhere so only the valid bit can prevent
    // a false hit on tag-3 addresses.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LINES; i++) begin
                s_tag[i]  <= 4'h3;
                s_data[i] <= 8'hEE;
            end
        end else if (sram_we) begin
            s_tag[s_idx]  <= sram_tag_in;
            s_data[s_idx] <= sram_data_in;
        end
    end

    // ---------------- Backing memory model
    logic [7:0] mem [256];
    logic       rvalid_en = 1'b1;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_pend_data = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[8'h35] = 8'hA7;
            mem[8'h45] = 8'h3B;
            mem_rvalid = 1'b0;
            rd_pend    = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_pend_data;
                rd_pend    = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end else if (rvalid_en) begin
                    rd_pend      = 1'b1;
                    rd_pend_data = mem[mem_addr];
                end
            end
        end
    end

    // ---------------- Activity monitor (sampled mid-cycle)
    int          n_sram_we = 0;
    int          n_mreq = 0;
    int          n_mwe = 0;
    int          n_resp = 0;
    int          n_bad_wl = 0;
    logic [15:0] last_wl = '0;
    logic [3:0]  last_tag = '0;
    logic [7:0]  last_data = '0;

    always @(negedge clk) begin
        if (sram_we) begin
            n_sram_we++;
            last_wl   = sram_wl;
            last_tag  = sram_tag_in;
            last_data = sram_data_in;
        end
        if (mem_req_valid) n_mreq++;
        if (mem_req_valid && mem_we) n_mwe++;
        if (resp_valid) n_resp++;
        if ((sram_wl != '0 && !$onehot(sram_wl)) || (sram_we && sram_wl == '0))
            n_bad_wl++;
    end

    // ---------------- Checking helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] r_data;
    logic       r_hit;
    int         r_cyc;
    int         d_we, d_mreq, d_mwe;

    // Issue one request from a negedge in IDLE, return at a negedge in IDLE.
    // r_cyc counts cycles from the accepting edge to the response cycle.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        int b_we, b_mreq, b_mwe;
        b_we   = n_sram_we;
        b_mreq = n_mreq;
        b_mwe  = n_mwe;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        r_cyc = 1;
        while (!resp_valid && r_cyc < 60) begin
            @(negedge clk);
            r_cyc++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 1);
        r_data = resp_rdata;
        r_hit  = resp_hit;
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 0);
        d_we   = n_sram_we - b_we;
        d_mreq = n_mreq - b_mreq;
        d_mwe  = n_mwe - b_mwe;
    endtask

    // ---------------- Directed sequence
    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_mem_req",    32'(mem_req_valid), 0);
        check("rst_sram_we",    32'(sram_we), 0);
        check("rst_sram_wl",    32'(sram_wl), 0);
        check("rst_hit_cnt",    32'(hit_count), 0);
        check("rst_miss_cnt",   32'(miss_count), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: read 0x35 misses (stale tag 3 but line invalid), fill line 5
        do_req(1'b0, 8'h35, 8'h00);
        check("t1_rdata",    32'(r_data), 'hA7);
        check("t1_hit",      32'(r_hit), 0);
        check("t1_latency",  32'(r_cyc), 5);
        check("t1_fill_cnt", 32'(d_we), 1);
        check("t1_fill_wl",  32'(last_wl), 'h0020);
        check("t1_fill_tag", 32'(last_tag), 'h3);
        check("t1_fill_dat", 32'(last_data), 'hA7);
        check("t1_mem_req",  32'(d_mreq), 1);
        check("t1_miss_cnt", 32'(miss_count), 1);

        // 2: re-read 0x35 hits, no memory traffic
        do_req(1'b0, 8'h35, 8'h00);
        check("t2_rdata",    32'(r_data), 'hA7);
        check("t2_hit",      32'(r_hit), 1);
        check("t2_latency",  32'(r_cyc), 2);
        check("t2_mem_req",  32'(d_mreq), 0);
        check("t2_sram_we",  32'(d_we), 0);
        check("t2_hit_cnt",  32'(hit_count), 1);

        // 3: conflicting tag on index 5 evicts, then old tag misses
        do_req(1'b0, 8'h45, 8'h00);
        check("t3_rdata",    32'(r_data), 'h3B);
        check("t3_hit",      32'(r_hit), 0);
        check("t3_fill_wl",  32'(last_wl), 'h0020);
        check("t3_fill_tag", 32'(last_tag), 'h4);
        do_req(1'b0, 8'h35, 8'h00);
        check("t3_re_hit",   32'(r_hit), 0);
        check("t3_re_rdata", 32'(r_data), 'hA7);
        check("t3_miss_cnt", 32'(miss_count), 3);
        do_req(1'b0, 8'h45, 8'h00);   // bring tag 4 back into line 5
        check("t3_back_tag", 32'(last_tag), 'h4);
        check("t3_miss_cnt2", 32'(miss_count), 4);

        // 4: write hit on 0x45 -> write-through plus line update
        do_req(1'b1, 8'h45, 8'h5C);
        check("t4_hit",      32'(r_hit), 1);
        check("t4_rdata",    32'(r_data), 'h5C);
        check("t4_mem_we",   32'(d_mwe), 1);
        check("t4_fill_cnt", 32'(d_we), 1);
        check("t4_fill_tag", 32'(last_tag), 'h4);
        check("t4_fill_dat", 32'(last_data), 'h5C);
        check("t4_latency",  32'(r_cyc), 4);
        check("t4_mem_data", 32'(mem[8'h45]), 'h5C);
        do_req(1'b0, 8'h45, 8'h00);
        check("t4_rd_rdata", 32'(r_data), 'h5C);
        check("t4_rd_hit",   32'(r_hit), 1);
        check("t4_rd_mreq",  32'(d_mreq), 0);
        check("t4_hit_cnt",  32'(hit_count), 3);

        // 5: write miss -> memory only; then flush with a competing request
        do_req(1'b1, 8'h12, 8'h9E);
        check("t5_hit",      32'(r_hit), 0);
        check("t5_rdata",    32'(r_data), 'h9E);
        check("t5_sram_we",  32'(d_we), 0);
        check("t5_mem_we",   32'(d_mwe), 1);
        check("t5_latency",  32'(r_cyc), 3);
        check("t5_mem_data", 32'(mem[8'h12]), 'h9E);
        check("t5_miss_cnt", 32'(miss_count), 5);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h45;
        #1;
        check("t5_flush_rdy", 32'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t5_flush_idle", 32'(req_ready), 1);
        @(negedge clk);
        do_req(1'b0, 8'h45, 8'h00);
        check("t5_post_hit",   32'(r_hit), 0);
        check("t5_post_rdata", 32'(r_data), 'h5C);
        check("t5_miss_cnt2",  32'(miss_count), 6);

        // 6: stall memory acceptance, then reset while waiting for read data
        mem_req_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h35;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_mreq_hold", 32'(mem_req_valid), 1);
            check("t6_maddr_hold", 32'(mem_addr), 'h35);
        end
        check("t6_miss_cnt", 32'(miss_count), 7);
        rvalid_en     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("t6_wait_mreq", 32'(mem_req_valid), 0);
        check("t6_wait_rdy",  32'(req_ready), 0);
        begin
            int resp_base;
            resp_base = n_resp;
            reset_n = 1'b0;
            @(negedge clk);
            check("t6_rst_rdy",   32'(req_ready), 1);
            check("t6_rst_mreq",  32'(mem_req_valid), 0);
            check("t6_rst_hit",   32'(hit_count), 0);
            check("t6_rst_miss",  32'(miss_count), 0);
            rvalid_en = 1'b1;
            @(negedge clk);
            reset_n = 1'b1;
            repeat (4) @(negedge clk);
            check("t6_no_resp",   32'(n_resp - resp_base), 0);
        end
        // Valid bits were cleared by reset: line 5 must miss again.
        do_req(1'b0, 8'h35, 8'h00);
        check("t6_post_hit",   32'(r_hit), 0);
        check("t6_post_rdata", 32'(r_data), 'hA7);
        check("t6_post_miss",  32'(miss_count), 1);
        check("wl_onehot",     32'(n_bad_wl), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
